// File: rtl/ascon_process_ciphertext.sv
// Ascon decryption pass: XORs ciphertext blocks into S0 to recover plaintext, permuting (p6) between full blocks.
// Applies final-block padding (partial block or an empty PAD step); done pulses once the final state is on x*_o.
module ascon_process_ciphertext #(
  parameter int LEN_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] ct_len,
  input  logic [63:0]      x0_i,
  input  logic [63:0]      x1_i,
  input  logic [63:0]      x2_i,
  input  logic [63:0]      x3_i,
  input  logic [63:0]      x4_i,
  input  logic             ct_valid,
  output logic             ct_ready,
  input  logic [63:0]      ct_data,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic [63:0]      pt_data,
  output logic [3:0]       pt_bytes,
  output logic [63:0]      x0_o,
  output logic [63:0]      x1_o,
  output logic [63:0]      x2_o,
  output logic [63:0]      x3_o,
  output logic [63:0]      x4_o,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, RECV, PERM, PAD, DONE} state_t;

  // Round constants of the last six Ascon rounds, first round in the top byte.
  localparam logic [47:0] RC_P6 = 48'h96_87_78_69_5a_4b;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_p6(input logic [319:0] s_in);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s_in;
    for (int r = 0; r < 6; r++) begin
      x2 = x2 ^ {56'd0, RC_P6[47-8*r -: 8]};
      x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
      x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
      x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
      x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  state_t           state_q, state_d;
  logic [63:0]      s_q [5];
  logic [63:0]      s_d [5];
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [63:0]      pt_data_q, pt_data_d;
  logic [3:0]       pt_bytes_q, pt_bytes_d;
  logic             pt_valid_q, pt_valid_d;

  logic [319:0] perm_out;
  logic         rem_ge8;
  logic [2:0]   part_n;
  logic [63:0]  keep_mask;
  logic [63:0]  pad_bit;

  assign perm_out  = ascon_p6({s_q[0], s_q[1], s_q[2], s_q[3], s_q[4]});
  assign rem_ge8   = |rem_q[LEN_W-1:3];
  assign part_n    = rem_q[2:0];
  // Partial block: top n bytes come from the ciphertext, the 0x80 pad lands in byte n.
  assign keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {part_n, 3'b000});
  assign pad_bit   = 64'h0000_0000_0000_0080 << {3'd7 - part_n, 3'b000};

  assign ct_ready = (state_q == RECV) && (rem_q != '0) && !pt_valid_q;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    rem_d      = rem_q;
    pt_data_d  = pt_data_q;
    pt_bytes_d = pt_bytes_q;
    pt_valid_d = pt_valid_q;
    if (pt_valid_q && pt_ready) pt_valid_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        s_d[0]  = x0_i;
        s_d[1]  = x1_i;
        s_d[2]  = x2_i;
        s_d[3]  = x3_i;
        s_d[4]  = x4_i;
        rem_d   = ct_len;
        state_d = RECV;
      end
      RECV: begin
        if (rem_q == '0) begin
          state_d = PAD;
        end else if (ct_valid && ct_ready) begin
          pt_valid_d = 1'b1;
          if (rem_ge8) begin
            pt_data_d  = s_q[0] ^ ct_data;
            pt_bytes_d = 4'd8;
            s_d[0]     = ct_data;
            rem_d      = rem_q - LEN_W'(8);
            state_d    = PERM;
          end else begin
            pt_data_d  = (s_q[0] ^ ct_data) & keep_mask;
            pt_bytes_d = {1'b0, part_n};
            s_d[0]     = ((ct_data & keep_mask) | (s_q[0] & ~keep_mask)) ^ pad_bit;
            rem_d      = '0;
            state_d    = DONE;
          end
        end
      end
      PERM: begin
        {s_d[0], s_d[1], s_d[2], s_d[3], s_d[4]} = perm_out;
        state_d = RECV;
      end
      PAD: begin
        s_d[0]  = s_q[0] ^ 64'h8000_0000_0000_0000;
        state_d = DONE;
      end
      DONE: if (!pt_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < 5; i++) s_q[i] <= '0;
      rem_q      <= '0;
      pt_data_q  <= '0;
      pt_bytes_q <= '0;
      pt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < 5; i++) s_q[i] <= s_d[i];
      rem_q      <= rem_d;
      pt_data_q  <= pt_data_d;
      pt_bytes_q <= pt_bytes_d;
      pt_valid_q <= pt_valid_d;
    end
  end

  assign pt_valid = pt_valid_q;
  assign pt_data  = pt_data_q;
  assign pt_bytes = pt_bytes_q;
  assign x0_o     = s_q[0];
  assign x1_o     = s_q[1];
  assign x2_o     = s_q[2];
  assign x3_o     = s_q[3];
  assign x4_o     = s_q[4];
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE) && !pt_valid_q;

endmodule

// File: doc/ascon_process_ciphertext.md
ASCON_PROCESS_CIPHERTEXT -- requirements
Module: ascon_process_ciphertext

Interface
REQ-001 Parameter LEN_W, default 32, bit width of ciphertext byte length.
REQ-002 clk  input  1  clock; all registers update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  begin decryption pass; sampled only in IDLE.
REQ-005 ct_len  input  LEN_W  ciphertext length in bytes; latched on accepted start.
REQ-006 x0_i..x4_i  input  64 each  Ascon state after associated-data processing; latched on accepted start.
REQ-007 ct_valid / ct_ready  input / output  1  ciphertext block handshake.
REQ-008 ct_data  input  64  ciphertext block; byte 0 = bits 63:56.
REQ-009 pt_valid / pt_ready  output / input  1  plaintext block handshake.
REQ-010 pt_data  output  64  plaintext block, byte 0 = bits 63:56.
REQ-011 pt_bytes  output  4  valid byte count of pt_data, 0..8.
REQ-012 x0_o..x4_o  output  64 each  internal state registers S0..S4, driven continuously.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when final state is valid on x*_o.

Function
REQ-015 FSM states IDLE, RECV, PERM, PAD, DONE; handshake transfer = valid AND ready in same cycle.
REQ-016 IDLE: start=1 loads S0..S4 from x*_i and rem from ct_len; next state RECV; start while busy ignored.
REQ-017 ct_ready = (state==RECV) AND (rem!=0) AND (pt_valid==0).
REQ-018 RECV, rem==0: no ct_ready; next state PAD.
REQ-019 RECV full block (rem>=8) on transfer: pt_data <= S0^ct_data, pt_bytes <= 8, pt_valid <= 1, S0 <= ct_data, rem <= rem-8, next PERM.
REQ-020 PERM: S0..S4 <= ascon_permutation_p6(S0..S4) in one cycle; next RECV.
REQ-021 RECV partial block (1<=rem<=7, n=rem) on transfer: pt_data top n bytes = S0^ct_data, remaining bytes 0; pt_bytes <= n; pt_valid <= 1.
REQ-022 Same transfer: S0 top n bytes <= ct_data top n bytes; S0 byte n <= S0 byte n ^ 0x80; other S0 bytes unchanged; rem <= 0; next DONE (no permutation).
REQ-023 Unused low ct_data bytes in partial block ignored.
REQ-024 PAD: S0 <= S0 ^ 0x8000_0000_0000_0000; next DONE.
REQ-025 DONE: waits while pt_valid==1; when pt_valid==0, done=1 for that cycle, next IDLE.
REQ-026 pt_valid set on block transfer, cleared on pt_valid AND pt_ready; pt_data/pt_bytes stable while pt_valid AND NOT pt_ready.
REQ-027 S1..S4 modified only in PERM; x*_o hold last value in IDLE.
REQ-028 rem arithmetic LEN_W bits, never underflows (subtract only when rem>=8).
REQ-029 Minimum latency full block: transfer cycle N, PERM N+1, RECV N+2.

Reset
REQ-030 rst_n low: state IDLE; S0..S4, rem, pt_data 0; pt_bytes 0; pt_valid, ct_ready, busy, done 0.
REQ-031 Reset assertion mid-pass aborts immediately; no done pulse; first start after release restarts cleanly.

Verification
REQ-032 ct_len=0, start -> no ct_ready, no pt_valid; RECV,PAD,DONE; done 3 cycles after start; x0_o=x0_i^0x8000_0000_0000_0000, x1_o..x4_o = x1_i..x4_i.
REQ-033 ct_len=3, x0_i=0x1122334455667788, ct_data=0xAABBCC0000000000 -> pt_data=0xBB99FF0000000000, pt_bytes=3; x0_o=0xAABBCCC455667788, x1..x4 unchanged, done pulse.
REQ-034 ct_len=8, ct_data=C -> pt_data=x0_i^C, pt_bytes=8; final x0_o = p6(C,x1_i..x4_i).x0 ^ 0x8000_0000_0000_0000; x1_o..x4_o = p6 outputs.
REQ-035 ct_len=16, pt_ready low 5 cycles after first block -> ct_ready low, pt_data stable for 5 cycles; second block accepted only after pt_ready; results match unstalled run.
REQ-036 start pulsed during busy, ct_len changed -> ignored, results use original ct_len.
REQ-037 rst_n low during PERM of ct_len=16 -> all outputs 0 next observation, busy 0, no done; subsequent ct_len=3 pass matches REQ-033.
